uart_transmitter: RTL



---
 rtl/uart_transmitter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Purpose: queues bytes from the host side in a small circular write FIFO and
// shifts each one out on tx as an 8N1 frame (start bit, d0..d7 LSB first,
// stop bit). Each serial bit is held for CLOCKS_PER_PULSE clock cycles, the
// same bit-timing convention as the companion receiver.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is sent after d7 (11 bit-periods/frame)
//   undefined -> plain 8N1 (10 bit-periods/frame)
//
// Parameters:
//   CLOCKS_PER_PULSE  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH        write FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   wr_en        in   write strobe; pushes data_in when full is low
//   data_in      in   byte to queue
//   full         out  FIFO holds FIFO_DEPTH entries
//   empty        out  FIFO holds no entries
//   busy         out  a frame is in progress (state != TX_IDLE)
//   tx           out  registered serial line, idles high
//   state_dbg_o  out  current FSM state encoding (observation only)
//
// Handshake: a write is accepted on any rising edge where wr_en is high and
// full is low; a write while full is dropped with no state change, even if
// the FSM pops in that same cycle. There is no back-pressure beyond full.
// -----------------------------------------------------------------------------
module uart_transmitter #(
   parameter int CLOCKS_PER_PULSE = 16,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] data_in,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       tx,
   output logic [2:0] state_dbg_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TCK_W = $clog2(CLOCKS_PER_PULSE);

   localparam logic [TCK_W-1:0] LAST_TICK = TCK_W'(CLOCKS_PER_PULSE - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      TX_PARITY = 3'd4,
`endif
      TX_STOP   = 3'd3
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push, pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   // full is the registered flag, so a same-cycle pop never frees a slot
   // for a write that arrives while full.
   assign push  = wr_en && !full;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t           state_q, state_d;
   logic [TCK_W-1:0] tick_q, tick_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             last_tick;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign last_tick = (tick_q == LAST_TICK);

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q + TCK_W'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
      tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         TX_IDLE: begin
            tick_d = '0;
            if (!empty) begin
               pop      = 1'b1;
               shift_d  = mem_q[rd_ptr_q];
               bit_d    = '0;
               state_d  = TX_START;
`ifdef UART_TX_PARITY_EN
               parity_d = ^mem_q[rd_ptr_q];
`endif
            end
         end
         TX_START: begin
            if (last_tick) begin
               tick_d  = '0;
               state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (last_tick) begin
               tick_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = TX_PARITY;
`else
                  state_d = TX_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         TX_PARITY: begin
            if (last_tick) begin
               tick_d  = '0;
               state_d = TX_STOP;
            end
         end
`endif
         TX_STOP: begin
            if (last_tick) begin
               tick_d = '0;
               // Chain straight into the next start bit when data is waiting.
               if (!empty) begin
                  pop      = 1'b1;
                  shift_d  = mem_q[rd_ptr_q];
                  bit_d    = '0;
                  state_d  = TX_START;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^mem_q[rd_ptr_q];
`endif
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: begin
            tick_d  = '0;
            state_d = TX_IDLE;
         end
      endcase

      // tx is registered from the next state so the line level changes on
      // the same edge as the state it belongs to.
      case (state_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         TX_PARITY: tx_d = parity_d;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= TX_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign tx          = tx_q;
   assign busy        = (state_q != TX_IDLE);
   assign state_dbg_o = state_q;

endmodule
